rescue_prime_arbiter: RTL

- Shares one Rescue-Prime permutation core among NUM_REQ requesters.
- Grants the core round-robin to one requester at a time.
- Per grant: streams that requester's NUM_WORDS input words into the core, starts the core, waits for done, then streams NUM_WORDS result words back to the same requester.
- Clears the core between jobs. Sits between the client ports and the serial-load permutation top.

---
 rtl/rescue_prime_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/rescue_prime_arbiter.sv
// Round-robin front end that time-shares one serial-load Rescue-Prime
// permutation core among NUM_REQ requesters. One job at a time: load
// NUM_WORDS words, start, wait for done, read NUM_WORDS results back, clear.
module rescue_prime_arbiter #(
  parameter int N_BITS    = 254,
  parameter int NUM_REQ   = 4,
  parameter int NUM_WORDS = 39,
  parameter int MAX_WAIT  = 4096
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*N_BITS-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [N_BITS-1:0]            rsp_data,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic                         core_wr,
  output logic [N_BITS-1:0]            core_wdata,
  output logic                         core_start,
  input  logic                         core_done,
  output logic                         core_rd,
  input  logic [N_BITS-1:0]            core_rdata,
  output logic                         core_clear,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         timeout_err
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(NUM_WORDS + 1);
  localparam int TW = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_RD_ISSUE, S_RD_HOLD, S_CLEAR
  } state_t;

  state_t              r_state;
  logic [GW-1:0]       r_rr;
  logic [GW-1:0]       r_grant;
  logic [CW-1:0]       r_wcnt;
  logic [CW-1:0]       r_rcnt;
  logic [TW-1:0]       r_wait;
  logic [N_BITS-1:0]   r_rsp_data;
  logic                r_hold_vld;   // result word captured, now presented

  logic [GW-1:0]       w_pick;
  logic                w_any;
  logic                w_gvalid;
  logic                w_wait_last;
  logic [GW-1:0]       w_rr_next;

  assign w_any       = |req_valid;
  assign w_gvalid    = req_valid[r_grant];
  assign w_wait_last = (r_wait == TW'(MAX_WAIT - 1));
  assign w_rr_next   = (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;

  // Cyclic priority search: lowest offset from the rr pointer wins, so scan
  // offsets high-to-low and let the last hit stand.
  always_comb begin
    int idx;
    w_pick = r_rr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(r_rr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[GW'(idx)]) w_pick = GW'(idx);
    end
  end

  // Job sequencer: grant, load, start, wait, read back word by word, clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rr       <= '0;
      r_grant    <= '0;
      r_wcnt     <= '0;
      r_rcnt     <= '0;
      r_wait     <= '0;
      r_rsp_data <= '0;
      r_hold_vld <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_grant <= w_pick;
          r_state <= S_LOAD;
        end
        S_LOAD: if (w_gvalid) begin
          r_wcnt <= r_wcnt + 1'b1;
          if (r_wcnt == CW'(NUM_WORDS - 1)) r_state <= S_START;
        end
        S_START: begin
          r_wait  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (core_done)        r_state <= S_RD_ISSUE;
          else if (w_wait_last) r_state <= S_CLEAR;
          else                  r_wait  <= r_wait + 1'b1;
        end
        S_RD_ISSUE: begin
          r_rcnt     <= r_rcnt + 1'b1;
          r_hold_vld <= 1'b0;
          r_state    <= S_RD_HOLD;
        end
        S_RD_HOLD: begin
          // Core data lands one cycle after core_rd; present it from then on.
          if (!r_hold_vld) begin
            r_rsp_data <= core_rdata;
            r_hold_vld <= 1'b1;
          end else if (rsp_ready[r_grant]) begin
            r_hold_vld <= 1'b0;
            r_state    <= (r_rcnt == CW'(NUM_WORDS)) ? S_CLEAR : S_RD_ISSUE;
          end
        end
        S_CLEAR: begin
          r_rr    <= w_rr_next;
          r_wcnt  <= '0;
          r_rcnt  <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Per-lane handshakes only ever point at the granted requester.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (r_state == S_LOAD)                req_ready[r_grant] = 1'b1;
    if (r_state == S_RD_HOLD && r_hold_vld) rsp_valid[r_grant] = 1'b1;
  end

  assign core_wr     = (r_state == S_LOAD) && w_gvalid;
  assign core_wdata  = req_data[r_grant*N_BITS +: N_BITS];
  assign core_start  = (r_state == S_START);
  assign core_rd     = (r_state == S_RD_ISSUE);
  assign core_clear  = reset || (r_state == S_CLEAR);
  assign timeout_err = (r_state == S_WAIT) && !core_done && w_wait_last;
  assign busy        = (r_state != S_IDLE);
  assign grant_id    = r_grant;
  assign rsp_data    = r_rsp_data;

endmodule
